board_rst_mgr: RTL and testbench

Parametrised board-level reset and status manager for the Guineveer FPGA top-level, running in the SoC clock domain. It debounces push-buttons and sequences an ordered, staggered release of `NUM_DOM` downstream reset domains (e.g. interconnect, peripherals, CPU). It supports button- and software-triggered warm resets and drives the status LEDs. It replaces the ad-hoc shift-register CPU reset and blinky counter in the board wrapper.

---
 rtl/board_rst_mgr_if.sv | 38 +++
 rtl/board_rst_mgr.sv | 219 +++++++++++++++++++++
 tb/tb_board_rst_mgr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/board_rst_mgr_if.sv
// rtl/board_rst_mgr_if.sv - button, warm-reset request and status bundle for board_rst_mgr
interface board_rst_mgr_if #(
  parameter int NUM_BTN = 4,
  parameter int NUM_DOM = 3
);
  logic [NUM_BTN-1:0] btn_i;
  logic               sw_rst_req_i;
  logic [NUM_BTN-1:0] btn_db_o;
  logic [NUM_BTN-1:0] btn_rise_o;
  logic [NUM_DOM-1:0] rstn_dom_o;
  logic               busy_o;
  logic [7:0]         rst_count_o;
  logic [3:0]         led_o;

  // Board wrapper / stimulus side
  modport master (
    output btn_i,
    output sw_rst_req_i,
    input  btn_db_o,
    input  btn_rise_o,
    input  rstn_dom_o,
    input  busy_o,
    input  rst_count_o,
    input  led_o
  );

  // Reset manager side
  modport slave (
    input  btn_i,
    input  sw_rst_req_i,
    output btn_db_o,
    output btn_rise_o,
    output rstn_dom_o,
    output busy_o,
    output rst_count_o,
    output led_o
  );
endinterface

// File: rtl/board_rst_mgr.sv
// rtl/board_rst_mgr.sv - button debounce, staggered domain reset release and status LEDs
module board_rst_mgr #(
  parameter int NUM_BTN         = 4,
  parameter int RST_BTN         = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_DOM         = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int REL_GAP         = 8,
  parameter int CNT_W           = 24,
  parameter int BLINK_BIT       = 20
) (
  input  logic           clk_soc,
  input  logic           rstn_soc,
  board_rst_mgr_if.slave bus
);

  localparam int DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > REL_GAP) ? HOLD_CYCLES : REL_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(REL_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ASSERT  = 2'd3
  } state_e;

  // Button path state
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] btn_db_q, btn_db_d;
  logic [NUM_BTN-1:0] btn_rise_q, btn_rise_d;
  logic [DW-1:0]      db_cnt_q [NUM_BTN];
  logic [DW-1:0]      db_cnt_d [NUM_BTN];

  // Sequencer state
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_DOM-1:0] rstn_dom_q, rstn_dom_d;
  logic [7:0]         rst_count_q, rst_count_d;
  logic               warm_seen_q, warm_seen_d;
  logic               active_q;

  // Status
  logic [CNT_W-1:0]   led_cnt_q, led_cnt_d;

  logic req;
  logic enter_assert;
  logic busy;
  logic unused_led_cnt;

  // Synchronise raw buttons and run one stability counter per button
  always_comb begin
    sync1_d  = bus.btn_i;
    sync2_d  = sync1_q;
    btn_db_d = btn_db_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != btn_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          btn_db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
    btn_rise_d = btn_db_d & ~btn_db_q;
  end

  // Register the button path
  always_ff @(posedge clk_soc or negedge rstn_soc) begin
    if (!rstn_soc) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      btn_db_q   <= '0;
      btn_rise_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_db_q   <= btn_db_d;
      btn_rise_q <= btn_rise_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign req = btn_db_q[RST_BTN] | bus.sw_rst_req_i;

  // Sequencer next state: a request always wins over a pending release step
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rstn_dom_d   = rstn_dom_q;
    enter_assert = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (req) begin
          enter_assert = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (req) begin
          enter_assert = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          rstn_dom_d[idx_q] = 1'b1;
          cnt_d             = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (req) begin
          enter_assert = 1'b1;
        end
      end
      ST_ASSERT: begin
        // A fresh software request stretches the hold; a held button blocks exit
        if (bus.sw_rst_req_i) begin
          cnt_d = '0;
        end else if ((cnt_q >= HOLD_LAST) && !btn_db_q[RST_BTN]) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (enter_assert) begin
      state_d    = ST_ASSERT;
      cnt_d      = '0;
      idx_d      = '0;
      rstn_dom_d = '0;
    end

    rst_count_d = rst_count_q;
    if (enter_assert && (rst_count_q != 8'hFF)) begin
      rst_count_d = rst_count_q + 8'd1;
    end
    warm_seen_d = warm_seen_q | enter_assert;
  end

  // Register the sequencer; active_q keeps busy_o low while the board reset is held
  always_ff @(posedge clk_soc or negedge rstn_soc) begin
    if (!rstn_soc) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rstn_dom_q  <= '0;
      rst_count_q <= '0;
      warm_seen_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rstn_dom_q  <= rstn_dom_d;
      rst_count_q <= rst_count_d;
      warm_seen_q <= warm_seen_d;
      active_q    <= 1'b1;
    end
  end

  assign led_cnt_d = led_cnt_q + CNT_W'(1);

  // Free-running heartbeat counter
  always_ff @(posedge clk_soc or negedge rstn_soc) begin
    if (!rstn_soc) begin
      led_cnt_q <= '0;
    end else begin
      led_cnt_q <= led_cnt_d;
    end
  end

  // Only two heartbeat taps are displayed
  assign unused_led_cnt = ^led_cnt_q;

  assign busy = active_q & (state_q != ST_RUN);

  assign bus.btn_db_o    = btn_db_q;
  assign bus.btn_rise_o  = btn_rise_q;
  assign bus.rstn_dom_o  = rstn_dom_q;
  assign bus.busy_o      = busy;
  assign bus.rst_count_o = rst_count_q;
  assign bus.led_o       = {warm_seen_q,
                            busy & led_cnt_q[BLINK_BIT-3],
                            led_cnt_q[BLINK_BIT],
                            state_q == ST_RUN};

endmodule

// File: tb/tb_board_rst_mgr.sv
// tb/tb_board_rst_mgr.sv - directed self-checking bench for board_rst_mgr
module tb_board_rst_mgr;

  logic clk_soc;
  logic rstn_soc;
  int   checks;
  int   failures;

  board_rst_mgr_if #(.NUM_BTN(4), .NUM_DOM(3)) bus ();

  board_rst_mgr #(
    .NUM_BTN(4), .RST_BTN(1), .DEBOUNCE_CYCLES(4), .NUM_DOM(3),
    .HOLD_CYCLES(4), .REL_GAP(8), .CNT_W(8), .BLINK_BIT(4)
  ) dut (
    .clk_soc  (clk_soc),
    .rstn_soc (rstn_soc),
    .bus      (bus)
  );

  initial clk_soc = 1'b0;
  always #5 clk_soc = ~clk_soc;

  task automatic tick();
    @(posedge clk_soc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_db"},    32'(bus.btn_db_o),    32'h0);
    chk({tag, "_rise"},  32'(bus.btn_rise_o),  32'h0);
    chk({tag, "_dom"},   32'(bus.rstn_dom_o),  32'h0);
    chk({tag, "_busy"},  32'(bus.busy_o),      32'h0);
    chk({tag, "_count"}, 32'(bus.rst_count_o), 32'h0);
    chk({tag, "_led"},   32'(bus.led_o),       32'h0);
  endtask

  // Cold release after rstn_soc rises: domains at edges 12, 20, 28
  task automatic cold_seq(input string tag);
    logic [2:0] e_dom;
    logic       e_busy;
    for (int n = 1; n <= 30; n++) begin
      tick();
      e_dom  = {(n >= 28), (n >= 20), (n >= 12)};
      e_busy = (n < 28);
      chk({tag, "_dom"},  32'(bus.rstn_dom_o), 32'(e_dom));
      chk({tag, "_busy"}, 32'(bus.busy_o),     32'(e_busy));
      chk({tag, "_led"},  32'(bus.led_o),
          32'({1'b0, e_busy & n[1], n[4], ~e_busy}));
    end
    chk({tag, "_count"}, 32'(bus.rst_count_o), 32'h0);
  endtask

  initial begin
    logic [2:0] e_dom;
    checks          = 0;
    failures        = 0;
    rstn_soc        = 1'b0;
    bus.btn_i       = '0;
    bus.sw_rst_req_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk_reset_outputs("reset");

    rstn_soc = 1'b1;
    cold_seq("cold");

    // 3-cycle glitch on button 2 must not change the debounced level
    bus.btn_i[2] = 1'b1;
    tick(); tick(); tick();
    bus.btn_i[2] = 1'b0;
    for (int n = 4; n <= 10; n++) begin
      tick();
      chk("glitch_db",   32'(bus.btn_db_o),   32'h0);
      chk("glitch_rise", 32'(bus.btn_rise_o), 32'h0);
    end

    // Stable press: level after edge 6, rise pulse only in that cycle
    bus.btn_i[2] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("press_db",   32'(bus.btn_db_o),   32'((n >= 6) ? 4'b0100 : 4'b0000));
      chk("press_rise", 32'(bus.btn_rise_o), 32'((n == 6) ? 4'b0100 : 4'b0000));
    end
    bus.btn_i[2] = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("unpress_db",   32'(bus.btn_db_o),   32'((n >= 6) ? 4'b0000 : 4'b0100));
      chk("unpress_rise", 32'(bus.btn_rise_o), 32'h0);
    end
    chk("unpress_dom", 32'(bus.rstn_dom_o), 32'h7);

    // Held warm-reset button for 100 cycles
    bus.btn_i[1] = 1'b1;
    for (int n = 1; n <= 7; n++) tick();
    chk("held_dom0",   32'(bus.rstn_dom_o),  32'h0);
    chk("held_count",  32'(bus.rst_count_o), 32'h1);
    chk("held_led3",   32'(bus.led_o[3]),    32'h1);
    chk("held_busy",   32'(bus.busy_o),      32'h1);
    for (int n = 8; n <= 100; n++) tick();
    chk("held_dom100", 32'(bus.rstn_dom_o),  32'h0);
    bus.btn_i[1] = 1'b0;
    for (int m = 101; m <= 132; m++) begin
      tick();
      e_dom = {(m >= 131), (m >= 123), (m >= 115)};
      chk("held_rel_dom", 32'(bus.rstn_dom_o), 32'(e_dom));
    end
    chk("held_run_led0", 32'(bus.led_o[0]),    32'h1);
    chk("held_count2",   32'(bus.rst_count_o), 32'h1);

    // Software reset from RUN, then again after domain 0 releases
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    chk("sw_run_dom",   32'(bus.rstn_dom_o),  32'h0);
    chk("sw_run_count", 32'(bus.rst_count_o), 32'h2);
    for (int n = 2; n <= 13; n++) begin
      tick();
      chk("sw_seq_dom", 32'(bus.rstn_dom_o), 32'((n >= 13) ? 3'b001 : 3'b000));
    end
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    chk("sw_rel_dom",   32'(bus.rstn_dom_o),  32'h0);
    chk("sw_rel_count", 32'(bus.rst_count_o), 32'h3);
    chk("sw_rel_busy",  32'(bus.busy_o),      32'h1);
    for (int n = 15; n <= 33; n++) begin
      tick();
      chk("sw_restart_dom", 32'(bus.rstn_dom_o), 32'((n >= 26) ? 3'b001 : 3'b000));
    end

    // Request lands on the same edge as domain 1 release: request wins
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    chk("tie_dom",   32'(bus.rstn_dom_o),  32'h0);
    chk("tie_count", 32'(bus.rst_count_o), 32'h4);
    for (int n = 35; n <= 62; n++) begin
      tick();
      e_dom = {(n >= 62), (n >= 54), (n >= 46)};
      chk("tie_seq_dom", 32'(bus.rstn_dom_o), 32'(e_dom));
    end
    chk("tie_led0", 32'(bus.led_o[0]), 32'h1);

    // Saturation of the warm-reset counter
    for (int i = 1; i <= 260; i++) begin
      bus.sw_rst_req_i = 1'b1;
      tick();
      bus.sw_rst_req_i = 1'b0;
      if (i == 250) chk("sat_254", 32'(bus.rst_count_o), 32'd254);
      if (i == 251) chk("sat_255", 32'(bus.rst_count_o), 32'd255);
      for (int k = 0; k < 7; k++) tick();
    end
    chk("sat_end", 32'(bus.rst_count_o), 32'd255);
    for (int n = 0; n < 30; n++) tick();
    chk("sat_run_dom", 32'(bus.rstn_dom_o), 32'h7);

    // Asynchronous reset in the middle of RELEASE
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    for (int n = 2; n <= 15; n++) tick();
    chk("async_pre_dom", 32'(bus.rstn_dom_o), 32'h1);
    rstn_soc = 1'b0;
    #2;
    chk_reset_outputs("async");
    tick();
    rstn_soc = 1'b1;
    cold_seq("recold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
